mc_pkt_gen: RTL and testbench

Multi-channel parametrised packet generator for the multi-port cache test environment. Drives CH_N independent ingress ports with framed packets (sop/vld/eop plus data), each made of one header word and a configurable or pseudo-random number of payload words. Each port supports per-channel ready backpressure and a programmable packet count. Sits upstream of the cache input ports in simulation and FPGA bring-up; frame counters on each port check the output.

---
 rtl/mc_pkt_gen.sv | 209 ++++++++++++++++++++
 tb/tb_mc_pkt_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_pkt_gen.sv
// mc_pkt_gen: CH_N independent framed packet generators (header + payload
// words) with per-channel ready backpressure, a shared start pulse and a
// per-channel Galois LFSR for random payload length and destination.
module mc_pkt_gen #(
  parameter int          CH_N   = 4,
  parameter int          DW     = 32,
  parameter int          LEN_W  = 6,
  parameter int          PORT_W = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [15:0]          i_pkt_num,
  input  logic                 i_len_mode,
  input  logic [LEN_W-1:0]     i_fix_len,
  input  logic [CH_N-1:0]      i_ready,
  output logic [CH_N-1:0]      o_sop,
  output logic [CH_N-1:0]      o_vld,
  output logic [CH_N-1:0]      o_eop,
  output logic [CH_N*DW-1:0]   o_data,
  output logic [CH_N-1:0]      o_done,
  output logic                 o_all_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PLD, ST_DONE} state_e;

  // 16-bit Galois LFSR, right shift, feedback mask 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Payload length for the next packet; zero is promoted to one.
  function automatic logic [LEN_W-1:0] pick_len(input logic mode,
                                                input logic [LEN_W-1:0] fix,
                                                input logic [LEN_W-1:0] rnd);
    logic [LEN_W-1:0] l;
    l = mode ? rnd : fix;
    if (l == '0) l = LEN_W'(1);
    return l;
  endfunction

  // Header word: {channel id, seq, dest, length}, fields zero-extended.
  function automatic logic [31:0] hdr_word(input logic [7:0] id,
                                           input logic [7:0] seq,
                                           input logic [PORT_W-1:0] dest,
                                           input logic [LEN_W-1:0] len);
    logic [31:0] w;
    w              = '0;
    w[31:24]       = id;
    w[23:16]       = seq;
    w[8 +: PORT_W] = dest;
    w[0 +: LEN_W]  = len;
    return w;
  endfunction

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    localparam logic [7:0]  CH_ID   = 8'(c);
    localparam logic [15:0] CH_SEED = SEED ^ 16'(c);

    state_e              state_q, state_d;
    logic [15:0]         pkt_num_q, pkt_num_d;
    logic                len_mode_q, len_mode_d;
    logic [LEN_W-1:0]    fix_len_q, fix_len_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [7:0]          seq_q, seq_d;
    logic [15:0]         sent_q, sent_d;
    logic [15:0]         idx_q, idx_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                sop_q, sop_d;
    logic                vld_q, vld_d;
    logic                eop_q, eop_d;
    logic                done_q, done_d;
    logic [DW-1:0]       data_q, data_d;
    logic                xfer;
    logic [LEN_W-1:0]    next_len;
    logic [PORT_W-1:0]   next_dest;

    // Next-state and next-output logic; outputs are registered copies.
    always_comb begin
      // NOTE: every variable gets a default here so no path leaves one
      // unassigned; an unassigned path in always_comb infers a latch.
      state_d    = state_q;
      pkt_num_d  = pkt_num_q;
      len_mode_d = len_mode_q;
      fix_len_d  = fix_len_q;
      len_d      = len_q;
      seq_d      = seq_q;
      sent_d     = sent_q;
      idx_d      = idx_q;
      lfsr_d     = lfsr_q;
      sop_d      = sop_q;
      vld_d      = vld_q;
      eop_d      = eop_q;
      done_d     = done_q;
      data_d     = data_q;
      xfer       = vld_q & i_ready[c];
      next_dest  = lfsr_q[8 +: PORT_W];
      next_len   = pick_len(len_mode_q, fix_len_q, lfsr_q[LEN_W-1:0]);

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            pkt_num_d  = i_pkt_num;
            len_mode_d = i_len_mode;
            fix_len_d  = i_fix_len;
            seq_d      = '0;
            sent_d     = '0;
            done_d     = 1'b0;
            if (i_pkt_num == 16'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HDR;
              len_d   = pick_len(i_len_mode, i_fix_len, lfsr_q[LEN_W-1:0]);
              vld_d   = 1'b1;
              sop_d   = 1'b1;
              eop_d   = 1'b0;
              data_d  = DW'(hdr_word(CH_ID, 8'h00, next_dest, len_d));
            end
          end
        end
        ST_HDR: begin
          if (xfer) begin
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = 16'd1;
            state_d = ST_PLD;
            sop_d   = 1'b0;
            eop_d   = (len_q == LEN_W'(1));
            data_d  = DW'({CH_ID, seq_q, 16'd1});
          end
        end
        ST_PLD: begin
          if (xfer) begin
            if (eop_q) begin
              seq_d  = seq_q + 8'd1;
              sent_d = sent_q + 16'd1;
              eop_d  = 1'b0;
              if (sent_d == pkt_num_q) begin
                state_d = ST_DONE;
                vld_d   = 1'b0;
                sop_d   = 1'b0;
                done_d  = 1'b1;
                data_d  = '0;
              end else begin
                // Back-to-back header: LFSR already stepped at the last header.
                state_d = ST_HDR;
                len_d   = next_len;
                sop_d   = 1'b1;
                data_d  = DW'(hdr_word(CH_ID, seq_d, next_dest, next_len));
              end
            end else begin
              idx_d  = idx_q + 16'd1;
              eop_d  = (idx_d == 16'(len_q));
              data_d = DW'({CH_ID, seq_q, idx_d});
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        pkt_num_q  <= '0;
        len_mode_q <= 1'b0;
        fix_len_q  <= '0;
        len_q      <= '0;
        seq_q      <= '0;
        sent_q     <= '0;
        idx_q      <= '0;
        lfsr_q     <= CH_SEED;
        sop_q      <= 1'b0;
        vld_q      <= 1'b0;
        eop_q      <= 1'b0;
        done_q     <= 1'b0;
        data_q     <= '0;
      end else begin
        state_q    <= state_d;
        pkt_num_q  <= pkt_num_d;
        len_mode_q <= len_mode_d;
        fix_len_q  <= fix_len_d;
        len_q      <= len_d;
        seq_q      <= seq_d;
        sent_q     <= sent_d;
        idx_q      <= idx_d;
        lfsr_q     <= lfsr_d;
        sop_q      <= sop_d;
        vld_q      <= vld_d;
        eop_q      <= eop_d;
        done_q     <= done_d;
        data_q     <= data_d;
      end
    end

    assign o_sop[c]             = sop_q;
    assign o_vld[c]             = vld_q;
    assign o_eop[c]             = eop_q;
    assign o_done[c]            = done_q;
    assign o_data[c*DW +: DW]   = data_q;
  end

  assign o_all_done = &o_done;

endmodule

// File: tb/tb_mc_pkt_gen.sv
// Testbench for mc_pkt_gen: table of run configurations, a per-channel
// scoreboard filled from a reference model at start, and a negedge monitor
// checking every transferred word, stall stability and frame counts.
module tb_mc_pkt_gen;
  localparam int          CH_N   = 4;
  localparam int          DW     = 32;
  localparam int          LEN_W  = 6;
  localparam int          PORT_W = 4;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          BUDGET = 20000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [15:0]          i_pkt_num = '0;
  logic                 i_len_mode = 1'b0;
  logic [LEN_W-1:0]     i_fix_len = '0;
  logic [CH_N-1:0]      i_ready = '1;
  logic [CH_N-1:0]      o_sop, o_vld, o_eop, o_done;
  logic [CH_N*DW-1:0]   o_data;
  logic                 o_all_done;

  mc_pkt_gen #(.CH_N(CH_N), .DW(DW), .LEN_W(LEN_W), .PORT_W(PORT_W), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pkt_num(i_pkt_num),
    .i_len_mode(i_len_mode), .i_fix_len(i_fix_len), .i_ready(i_ready),
    .o_sop(o_sop), .o_vld(o_vld), .o_eop(o_eop), .o_data(o_data),
    .o_done(o_done), .o_all_done(o_all_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [15:0]      pkt;
    logic             mode;
    logic [LEN_W-1:0] fix;
    int               stall;      // 0 all ready, 1 ch1 pattern 1,0,0, 2 random ch1..3
    bit               no_reset;
    int               busy_at;    // cycle of an ignored i_start pulse (0 = none)
    int               abort_at;   // stop early at this cycle (0 = run to done)
    int               exp_done0;  // cycle ch0 reports done (0 = not checked)
    logic [31:0]      exp_hdr0;   // first ch0 header (0 = not checked)
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  word_t       exp_q [CH_N][$];
  logic [15:0] m_lfsr [CH_N];
  int          sop_cnt [CH_N];
  int          eop_cnt [CH_N];
  word_t       held [CH_N];
  logic [CH_N-1:0] hold_v = '0;
  logic [31:0] first_hdr0;
  bit          hdr0_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference model: expand the whole run for every channel into its queue.
  task automatic model_start(input logic [15:0] pkt, input logic mode, input logic [LEN_W-1:0] fix);
    logic [7:0]       seq;
    logic [LEN_W-1:0] l;
    logic [3:0]       dest;
    word_t            w;
    for (int c = 0; c < CH_N; c++) begin
      seq = 8'h00;
      for (int p = 0; p < int'(pkt); p++) begin
        l    = mode ? m_lfsr[c][LEN_W-1:0] : fix;
        if (l == '0) l = 1;
        dest = m_lfsr[c][11:8];
        w.sop = 1'b1; w.eop = 1'b0;
        w.data = {8'(c), seq, 4'h0, dest, 2'b00, l};
        exp_q[c].push_back(w);
        m_lfsr[c] = ref_step(m_lfsr[c]);
        for (int i = 1; i <= int'(l); i++) begin
          w.sop = 1'b0; w.eop = (i == int'(l));
          w.data = {8'(c), seq, 16'(i)};
          exp_q[c].push_back(w);
        end
        seq = seq + 8'd1;
      end
    end
  endtask

  // Monitor: scoreboard compare on every transfer, hold check while stalled.
  always @(negedge clk) begin
    word_t cur;
    word_t exp_w;
    if (!rst_n) begin
      hold_v = '0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        cur = {o_sop[c], o_eop[c], o_data[c*DW +: DW]};
        if (hold_v[c]) begin
          check($sformatf("hold_vld ch%0d", c), 64'(o_vld[c]), 64'd1);
          check($sformatf("hold_word ch%0d", c), 64'(cur), 64'(held[c]));
        end
        if (o_vld[c] && !i_ready[c]) begin
          hold_v[c] = 1'b1;
          held[c]   = cur;
        end else begin
          hold_v[c] = 1'b0;
        end
        if (o_vld[c] && i_ready[c]) begin
          if (cur.sop) begin
            sop_cnt[c]++;
            check($sformatf("hdr_fields ch%0d", c),
                  64'(cur.data[7:0] >= 8'd1 && cur.data[7:0] <= 8'd63 && cur.data[15:8] < 8'd16), 64'd1);
            if (c == 0 && !hdr0_seen) begin
              first_hdr0 = cur.data;
              hdr0_seen  = 1'b1;
            end
          end
          if (cur.eop) eop_cnt[c]++;
          check($sformatf("sb_has_word ch%0d", c), 64'(exp_q[c].size() != 0), 64'd1);
          if (exp_q[c].size() != 0) begin
            exp_w = exp_q[c].pop_front();
            check($sformatf("sb_word ch%0d", c), 64'(cur), 64'(exp_w));
          end
        end
      end
    end
  end

  // Reset for two edges; outputs must be zero after the first sampled edge.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; i_start = 1'b0; i_ready = '1;
    @(posedge clk);
    @(negedge clk);
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_sop", 64'(o_sop), 64'd0);
    check("rst_eop", 64'(o_eop), 64'd0);
    check("rst_data_lo", o_data[63:0], 64'd0);
    check("rst_data_hi", o_data[127:64], 64'd0);
    check("rst_done", {59'd0, o_all_done, o_done}, 64'd0);
    for (int c = 0; c < CH_N; c++) begin
      exp_q[c].delete();
      m_lfsr[c] = SEED ^ 16'(c);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    int done0;
    if (!v.no_reset) do_reset();
    for (int c = 0; c < CH_N; c++) begin
      sop_cnt[c] = 0;
      eop_cnt[c] = 0;
    end
    hdr0_seen = 1'b0;
    first_hdr0 = '0;
    @(posedge clk); #2;
    i_pkt_num = v.pkt; i_len_mode = v.mode; i_fix_len = v.fix; i_start = 1'b1;
    model_start(v.pkt, v.mode, v.fix);
    @(posedge clk); #2;
    i_start = 1'b0;
    cyc = 0;
    done0 = 0;
    while (cyc < BUDGET) begin
      i_ready = '1;
      if (v.stall == 1) i_ready[1] = (cyc % 3 == 0);
      if (v.stall == 2) for (int c = 1; c < CH_N; c++) i_ready[c] = 1'($urandom_range(0, 1));
      i_start = (v.busy_at != 0 && cyc == v.busy_at);
      if (i_start) begin
        i_pkt_num = 16'd7; i_len_mode = 1'b1; i_fix_len = 6'd2;
      end
      @(negedge clk);
      cyc++;
      if (o_done[0] && done0 == 0) done0 = cyc;
      check($sformatf("v%0d all_done_and", n), 64'(o_all_done), 64'(&o_done));
      if (o_all_done || (v.abort_at != 0 && cyc == v.abort_at)) break;
      @(posedge clk); #2;
    end
    if (v.abort_at != 0) return;
    check($sformatf("v%0d timeout", n), 64'(o_all_done), 64'd1);
    if (v.exp_done0 != 0) check($sformatf("v%0d done_cycle ch0", n), 64'(done0), 64'(v.exp_done0));
    if (v.exp_hdr0 != 0)  check($sformatf("v%0d first_hdr ch0", n), 64'(first_hdr0), 64'(v.exp_hdr0));
    for (int c = 0; c < CH_N; c++) begin
      check($sformatf("v%0d sb_empty ch%0d", n, c), 64'(exp_q[c].size()), 64'd0);
      check($sformatf("v%0d sop_count ch%0d", n, c), 64'(sop_cnt[c]), 64'(v.pkt));
      check($sformatf("v%0d eop_count ch%0d", n, c), 64'(eop_cnt[c]), 64'(v.pkt));
    end
    check($sformatf("v%0d vld_idle", n), 64'(o_vld), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    //         pkt     mode  fix    stall nr    busy abort done hdr0
    vecs[0] = '{16'd2,   1'b0, 6'd3,  0, 1'b0, 0,  0, 9,  32'h0000_0C03};
    vecs[1] = '{16'd2,   1'b0, 6'd5,  1, 1'b0, 0,  0, 13, 32'h0000_0C05};
    vecs[2] = '{16'd0,   1'b0, 6'd3,  0, 1'b0, 0,  0, 1,  32'h0};
    vecs[3] = '{16'd1,   1'b0, 6'd0,  0, 1'b0, 0,  0, 3,  32'h0000_0C01};
    vecs[4] = '{16'd1,   1'b0, 6'd63, 0, 1'b0, 10, 0, 65, 32'h0000_0C3F};
    vecs[5] = '{16'd3,   1'b1, 6'd0,  0, 1'b0, 0,  0, 0,  32'h0000_0C21};
    vecs[6] = '{16'd4,   1'b1, 6'd0,  0, 1'b1, 0,  0, 0,  32'h0};
    vecs[7] = '{16'd100, 1'b1, 6'd0,  2, 1'b0, 0,  0, 0,  32'h0000_0C21};
    vecs[8] = '{16'd1,   1'b0, 6'd10, 0, 1'b0, 0,  4, 0,  32'h0};
    vecs[9] = '{16'd1,   1'b0, 6'd10, 0, 1'b0, 0,  0, 12, 32'h0000_0C0A};

    for (int c = 0; c < CH_N; c++) m_lfsr[c] = SEED ^ 16'(c);
    repeat (2) @(posedge clk);

    for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

endmodule
